uop_sequencer: RTL
==================

UOP_SEQUENCER -- requirements
Module: uop_sequencer

Interface
REQ-001 Parameter ADDR_W, default 6, microprogram address width.
REQ-002 Parameter DATA_W, default 20, microinstruction width; layout opcode[19:16], src_a[15:12], src_b[11:8], dst[7:4], exec[3:0], values per the shared ecdsa microcode header.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 ena  input  1  start pulse; sampled only in IDLE.
REQ-006 rdy  output  1  high when idle/finished.
REQ-007 err  output  1  high when the last run ended by address overflow.
REQ-008 uop_addr  output  ADDR_W  registered address to microcode ROM (ROM read latency 1 cycle).
REQ-009 uop_data  input  DATA_W  ROM output word.
REQ-010 op_ena  output  1  one-cycle pulse issuing an operation to the datapath.
REQ-011 op_code, op_src_a, op_src_b, op_dst  output  4 each  registered fields of the issued microinstruction, stable from op_ena until op_done.
REQ-012 op_done  input  1  datapath completion pulse.
REQ-013 cmp_eq  input  1  compare result, valid with op_done of a CMP.

Function
REQ-014 States: IDLE, FETCH, DECODE, EXEC; encoding free.
REQ-015 IDLE: ena=1 -> uop_addr<=0, rdy<=0, err<=0, flags<=000, state FETCH; ena=0 -> stay.
REQ-016 FETCH: one cycle (ROM samples uop_addr) -> DECODE.
REQ-017 DECODE: uop_data valid; evaluate opcode and exec field this cycle.
REQ-018 Opcode RDY -> rdy<=1, state IDLE, no op_ena.
REQ-019 Condition flags {pz_zero, t1_zero, t2_zero}; exec=ALWAYS executes unconditionally; a conditional exec code executes only when every flag it requires is set (PZT1T2_0XX requires pz_zero=1).
REQ-020 Skipped microinstruction: no op_ena, uop_addr<=uop_addr+1, state FETCH.
REQ-021 Executed microinstruction: latch op_* fields, op_ena<=1 for exactly one cycle, state EXEC.
REQ-022 EXEC: wait for op_done; op_done in the cycle op_ena is high is ignored; on op_done -> uop_addr+1, state FETCH.
REQ-023 On op_done of CMP: flag selected by src_a (PZ->pz_zero, T1->t1_zero, T2->t2_zero) <= cmp_eq; other src_a codes change no flag.
REQ-024 Minimum per-instruction cost: 2 cycles skipped, 4 cycles executed with op_done one cycle after op_ena.
REQ-025 Address overflow: non-RDY instruction completes at address 2^ADDR_W-1 -> rdy<=1, err<=1, state IDLE, no wrap to 0.
REQ-026 ena while not IDLE ignored; op_done outside EXEC ignored.
REQ-027 Flags persist from CMP until next start; never cleared mid-run.

Reset
REQ-028 rst=1 at any clock edge, including mid-run, forces IDLE, rdy=1, err=0, op_ena=0, uop_addr=0, op_* fields=0, flags=000; no pending operation resumes.
REQ-029 Reset has priority over ena and op_done in the same cycle.

Verification
REQ-030 Reset then idle 5 cycles -> rdy=1, err=0, op_ena=0, uop_addr=0 throughout.
REQ-031 Doubling ROM, PZ nonzero (CMP cmp_eq=0), op_done 1 cycle after each op_ena -> 24 op_ena pulses, addr 24..26 skipped, rdy rises after DECODE at addr 27, err=0.
REQ-032 Same with cmp_eq=0 on CMP reversed (cmp_eq=1) -> 27 op_ena pulses, last three MOV ONE->RX, ONE->RY, ZERO->RZ issued.
REQ-033 op_done delayed 10 cycles on MUL at addr 2 -> op_* fields stable, uop_addr held at 2, no extra op_ena.
REQ-034 ROM with no RDY word (all ADD ALWAYS) -> 64 op_ena pulses, then rdy=1, err=1.
REQ-035 rst asserted during EXEC at addr 5, ena pulsed 2 cycles later -> clean restart at addr 0, flags 000, ena during run ignored.

Source files
------------

// File: rtl/uop_sequencer.sv
// Microcode sequencer: fetches microinstructions from a 1-cycle-latency ROM,
// evaluates condition flags, and issues operations to the datapath one at a time.
module uop_sequencer #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  output logic              rdy,
  output logic              err,
  output logic [ADDR_W-1:0] uop_addr,
  input  logic [DATA_W-1:0] uop_data,
  output logic              op_ena,
  output logic [3:0]        op_code,
  output logic [3:0]        op_src_a,
  output logic [3:0]        op_src_b,
  output logic [3:0]        op_dst,
  input  logic              op_done,
  input  logic              cmp_eq
);

  localparam logic [3:0] OP_CMP = 4'h3;
  localparam logic [3:0] OP_RDY = 4'hF;

  localparam logic [3:0] REG_PZ = 4'h4;
  localparam logic [3:0] REG_T1 = 4'h8;
  localparam logic [3:0] REG_T2 = 4'h9;

  localparam logic [3:0] EXEC_ALWAYS      = 4'h0;
  localparam logic [3:0] EXEC_PZT1T2_0XX  = 4'h1;
  localparam logic [3:0] EXEC_PZT1T2_X0X  = 4'h2;
  localparam logic [3:0] EXEC_PZT1T2_XX0  = 4'h3;
  localparam logic [3:0] EXEC_PZT1T2_X00  = 4'h4;
  localparam logic [3:0] EXEC_PZT1T2_000  = 4'h5;

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  typedef enum logic [1:0] {IDLE, FETCH, DECODE, EXEC} state_t;

  state_t      state, state_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic        rdy_nxt, err_nxt, op_ena_nxt, step;
  logic [3:0]  code_nxt, src_a_nxt, src_b_nxt, dst_nxt;
  logic [2:0]  flags, flags_nxt;  // {pz_zero, t1_zero, t2_zero}

  logic [3:0]  dec_code, dec_a, dec_b, dec_dst, dec_exec;
  assign dec_code = uop_data[19:16];
  assign dec_a    = uop_data[15:12];
  assign dec_b    = uop_data[11:8];
  assign dec_dst  = uop_data[7:4];
  assign dec_exec = uop_data[3:0];

  // Unknown exec codes are treated as never satisfied.
  function automatic logic exec_ok(input logic [3:0] code, input logic [2:0] f);
    logic [2:0] need;
    logic       known;
    need  = 3'b000;
    known = 1'b1;
    case (code)
      EXEC_ALWAYS:     need = 3'b000;
      EXEC_PZT1T2_0XX: need = 3'b100;
      EXEC_PZT1T2_X0X: need = 3'b010;
      EXEC_PZT1T2_XX0: need = 3'b001;
      EXEC_PZT1T2_X00: need = 3'b011;
      EXEC_PZT1T2_000: need = 3'b111;
      default:         known = 1'b0;
    endcase
    return known && ((f & need) == need);
  endfunction

  always_comb begin
    state_nxt  = state;
    addr_nxt   = uop_addr;
    rdy_nxt    = rdy;
    err_nxt    = err;
    op_ena_nxt = 1'b0;
    code_nxt   = op_code;
    src_a_nxt  = op_src_a;
    src_b_nxt  = op_src_b;
    dst_nxt    = op_dst;
    flags_nxt  = flags;
    step       = 1'b0;
    case (state)
      IDLE: begin
        if (ena) begin
          addr_nxt  = '0;
          rdy_nxt   = 1'b0;
          err_nxt   = 1'b0;
          flags_nxt = 3'b000;
          state_nxt = FETCH;
        end
      end
      FETCH: state_nxt = DECODE;
      DECODE: begin
        if (dec_code == OP_RDY) begin
          rdy_nxt   = 1'b1;
          state_nxt = IDLE;
        end else if (exec_ok(dec_exec, flags)) begin
          code_nxt   = dec_code;
          src_a_nxt  = dec_a;
          src_b_nxt  = dec_b;
          dst_nxt    = dec_dst;
          op_ena_nxt = 1'b1;
          state_nxt  = EXEC;
        end else begin
          step = 1'b1;
        end
      end
      EXEC: begin
        // A completion seen while op_ena is still high belongs to no issued op.
        if (op_done && !op_ena) begin
          step = 1'b1;
          if (op_code == OP_CMP) begin
            case (op_src_a)
              REG_PZ:  flags_nxt[2] = cmp_eq;
              REG_T1:  flags_nxt[1] = cmp_eq;
              REG_T2:  flags_nxt[0] = cmp_eq;
              default: flags_nxt    = flags;
            endcase
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (step) begin
      if (uop_addr == ADDR_LAST) begin
        rdy_nxt   = 1'b1;
        err_nxt   = 1'b1;
        state_nxt = IDLE;
      end else begin
        addr_nxt  = uop_addr + 1'b1;
        state_nxt = FETCH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      uop_addr <= '0;
      rdy      <= 1'b1;
      err      <= 1'b0;
      op_ena   <= 1'b0;
      op_code  <= 4'h0;
      op_src_a <= 4'h0;
      op_src_b <= 4'h0;
      op_dst   <= 4'h0;
      flags    <= 3'b000;
    end else begin
      state    <= state_nxt;
      uop_addr <= addr_nxt;
      rdy      <= rdy_nxt;
      err      <= err_nxt;
      op_ena   <= op_ena_nxt;
      op_code  <= code_nxt;
      op_src_a <= src_a_nxt;
      op_src_b <= src_b_nxt;
      op_dst   <= dst_nxt;
      flags    <= flags_nxt;
    end
  end

endmodule
